// File: rtl/booth_divider_seq.sv
// booth_divider_seq: signed 32/16 restoring divider, one quotient bit per clock, saturating quotient.
module booth_divider_seq #(
  parameter int DW = 32,
  parameter int QW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [QW-1:0] divisor,
  output logic [QW-1:0] quotient,
  output logic [QW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic          dbz
);
  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] QPOS = DW'((2 ** (QW - 1)) - 1);
  localparam logic [DW-1:0] QNEG = DW'(2 ** (QW - 1));
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_n;
  logic [DW-1:0] nq;
  logic [QW:0] pr, mag_d, sh;
  logic [QW+1:0] diff;
  logic [CW-1:0] cnt;
  logic sn, sd, neg_q, ovf_c, zero_d;
  logic [QW-1:0] q_c, r_c;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = (divisor == '0) ? FIX : CALC;
      CALC: if (cnt == '0) state_n = FIX;
      FIX:  state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    busy = (state == CALC) || (state == FIX);
    done = (state == DONE);
  end
  // nq holds |N| and collects quotient bits in its LSBs as the dividend shifts out
  always_comb begin
    sh = {pr[QW-1:0], nq[DW-1]};
    diff = {1'b0, sh} - {1'b0, mag_d};
    neg_q = sn ^ sd;
    zero_d = (mag_d == '0);
    ovf_c = neg_q ? (nq > QNEG) : (nq > QPOS);
    q_c = ovf_c ? (neg_q ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}})
        : (neg_q ? -nq[QW-1:0] : nq[QW-1:0]);
    r_c = sn ? -pr[QW-1:0] : pr[QW-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nq <= '0;
      pr <= '0;
      mag_d <= '0;
      cnt <= '0;
      sn <= 1'b0;
      sd <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      ovf <= 1'b0;
      dbz <= 1'b0;
    end else if (state == IDLE && start) begin
      sn <= dividend[DW-1];
      sd <= divisor[QW-1];
      nq <= dividend[DW-1] ? -dividend : dividend;
      mag_d <= divisor[QW-1] ? -{1'b1, divisor} : {1'b0, divisor};
      pr <= '0;
      cnt <= CW'(DW - 1);
      ovf <= 1'b0;
      dbz <= 1'b0;
    end else if (state == CALC) begin
      pr <= diff[QW+1] ? sh : diff[QW:0];
      nq <= {nq[DW-2:0], ~diff[QW+1]};
      cnt <= cnt - 1'b1;
    end else if (state == FIX) begin
      dbz <= zero_d;
      ovf <= !zero_d && ovf_c;
      quotient <= zero_d ? '0 : q_c;
      remainder <= zero_d ? '0 : r_c;
    end
  end
endmodule

// File: tb/tb_booth_divider_seq.sv
// tb_booth_divider_seq: directed vectors with hand-computed quotient, remainder, flags and latency.
module tb_booth_divider_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quotient, remainder;
  logic busy, done, ovf, dbz;
  int tests = 0;
  int failed = 0;
  int lat;
  int seen;

  booth_divider_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .ovf(ovf), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] n, input logic [15:0] d);
    @(negedge clk);
    dividend = n;
    divisor = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] n, input logic [15:0] d,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic eo, input logic ez, input int elat);
    int l;
    start_op(n, d);
    wait_done(l);
    chk({tag, ".lat"}, l, elat);
    chk({tag, ".q"}, 32'(quotient), 32'(eq));
    chk({tag, ".r"}, 32'(remainder), 32'(er));
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
    chk({tag, ".dbz"}, 32'(dbz), 32'(ez));
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.q", 32'(quotient), 32'd0);
    chk("rst.r", 32'(remainder), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.flags", {30'd0, ovf, dbz}, 32'd0);
    rst_n = 1'b1;
    do_op("basic", 32'd2400, 16'd96, 16'd25, 16'd0, 1'b0, 1'b0, 33);
    do_op("big", -32'sd6360354, 16'd32123, -16'sd198, 16'd0, 1'b0, 1'b0, 33);
    do_op("ext", 32'd1073741824, 16'h8000, 16'h8000, 16'd0, 1'b0, 1'b0, 33);
    do_op("n7d2", -32'sd7, 16'd2, -16'sd3, -16'sd1, 1'b0, 1'b0, 33);
    do_op("p7dn2", 32'd7, -16'sd2, -16'sd3, 16'd1, 1'b0, 1'b0, 33);
    do_op("n1008", 32'd1008, -16'sd63, -16'sd16, 16'd0, 1'b0, 1'b0, 33);
    do_op("ovfp", 32'h40000000, 16'd1, 16'h7fff, 16'd0, 1'b1, 1'b0, 33);
    do_op("ovfn", 32'h80000000, 16'd1, 16'h8000, 16'd0, 1'b1, 1'b0, 33);
    do_op("dbz", 32'd12345, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 1);
    do_op("after", 32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 33);
    start_op(32'd2400, 16'd96);
    chk("mid.busy", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    dividend = 32'd999;
    divisor = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("mid.lat", lat, 28);
    chk("mid.q", 32'(quotient), 32'd25);
    chk("mid.r", 32'(remainder), 32'd0);
    @(negedge clk);
    start_op(32'd100, 16'd7);
    repeat (10) @(negedge clk);
    chk("abort.busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.q", 32'(quotient), 32'd0);
    chk("abort.r", 32'(remainder), 32'd0);
    chk("abort.ctl", {28'd0, busy, done, ovf, dbz}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort.nodone", seen, 0);
    do_op("restart", 32'd9345, -16'sd105, -16'sd89, 16'd0, 1'b0, 1'b0, 33);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
